// File: rtl/alu_pkg.sv
// Shared definitions for the ALU accumulator/sequencer stage: opcodes, FSM state type, default width.
package alu_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ADC  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic {IDLE, EXEC} state_t;

endpackage

// File: rtl/alu_flags.sv
// Combinational flag derivation from the ALU operands and result.
// Overflow output exists only when ACC_OVF_EN is defined.
module alu_flags
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] Y,
  input  logic [1:0]       OP,
`ifdef ACC_OVF_EN
  output logic             overflow,
`endif
  output logic             zero
);

  assign zero = (Y == '0);

`ifdef ACC_OVF_EN
  logic w_sa, w_sb, w_sy;
  assign w_sa = A[WIDTH-1];
  assign w_sb = B[WIDTH-1];
  assign w_sy = Y[WIDTH-1];

  always_comb begin
    overflow = 1'b0;
    case (OP)
      OP_ADC:  overflow = (w_sa == w_sb) && (w_sy != w_sa);
      OP_SUB:  overflow = (w_sa != w_sb) && (w_sy != w_sa);
      default: overflow = 1'b0;
    endcase
  end
`else
  logic w_unused;
  assign w_unused = ^{A, B, OP};
`endif

endmodule

// File: rtl/alu_acc_ctrl.sv
// Accumulator/sequencer wrapped around an external 8-bit ALU: accept, execute one cycle, capture.
// Optional signed-overflow flag VF is enabled by defining ACC_OVF_EN.
module alu_acc_ctrl
  import alu_pkg::*;
#(
  parameter int               WIDTH    = WIDTH_DEF,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [WIDTH-1:0] CMD_B,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic             ALU_CY,
  output logic [1:0]       ALU_OP,
  input  logic [WIDTH-1:0] ALU_Y,
  input  logic             ALU_ST,
  output logic [WIDTH-1:0] ACC,
  output logic             CF,
  output logic             ZF,
`ifdef ACC_OVF_EN
  output logic             VF,
`endif
  output logic             DONE
);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc, r_b;
  logic [1:0]       r_op;
  logic             r_cf, r_zf, r_done;
  logic             w_accept, w_capture, w_ready, w_zero;

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (CMD_VALID) begin
          w_accept    = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        w_capture   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef ACC_OVF_EN
  logic r_vf, w_ovf;
  alu_flags #(.WIDTH(WIDTH)) u_flags (
    .A(r_acc), .B(r_b), .Y(ALU_Y), .OP(r_op), .overflow(w_ovf), .zero(w_zero)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            r_vf <= 1'b0;
    else if (w_capture) r_vf <= w_ovf;
  end
  assign VF = r_vf;
`else
  alu_flags #(.WIDTH(WIDTH)) u_flags (
    .A(r_acc), .B(r_b), .Y(ALU_Y), .OP(r_op), .zero(w_zero)
  );
`endif

  // ACC/CF only move at capture, so ALU_A/ALU_CY are stable through EXEC.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_acc   <= ACC_INIT;
      r_cf    <= 1'b0;
      r_zf    <= (ACC_INIT == '0);
      r_op    <= OP_PASS;
      r_b     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_capture;
      if (w_accept) begin
        r_op <= CMD_OP;
        r_b  <= CMD_B;
      end
      if (w_capture) begin
        r_acc <= ALU_Y;
        r_cf  <= ALU_ST;
        r_zf  <= w_zero;
      end
    end
  end

  assign CMD_READY = w_ready;
  assign ALU_A     = r_acc;
  assign ALU_B     = r_b;
  assign ALU_CY    = r_cf;
  assign ALU_OP    = r_op;
  assign ACC       = r_acc;
  assign CF        = r_cf;
  assign ZF        = r_zf;
  assign DONE      = r_done;

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Self-checking bench: behavioural 8-bit ALU beside the DUT, arithmetic reference model, random + directed commands.
module tb_alu_acc_ctrl;
  import alu_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [1:0] CMD_OP;
  logic [7:0] CMD_B;
  logic [7:0] ALU_A, ALU_B, ALU_Y, ACC;
  logic       ALU_CY, ALU_ST, CF, ZF, DONE;
  logic [1:0] ALU_OP;
`ifdef ACC_OVF_EN
  logic       VF;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] m_acc;
  logic       m_cf, m_zf, m_vf;
  logic [8:0] alu_r;
  logic       d_prev;

  alu_acc_ctrl #(.WIDTH(8), .ACC_INIT(8'h00)) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_B(CMD_B), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .ALU_CY(ALU_CY), .ALU_OP(ALU_OP), .ALU_Y(ALU_Y), .ALU_ST(ALU_ST),
    .ACC(ACC), .CF(CF), .ZF(ZF),
`ifdef ACC_OVF_EN
    .VF(VF),
`endif
    .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // The ALU that sits beside the block at top level.
  always_comb begin
    alu_r = '0;
    case (ALU_OP)
      2'b00: alu_r = {1'b0, ALU_A};
      2'b01: alu_r = {1'b0, ALU_A} + {1'b0, ALU_B} + {8'b0, ALU_CY};
      2'b10: alu_r = {1'b0, ALU_A} - {1'b0, ALU_B};
      default: alu_r = '0;
    endcase
  end
  assign ALU_Y  = alu_r[7:0];
  assign ALU_ST = alu_r[8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 8'h00; m_cf = 1'b0; m_zf = 1'b1; m_vf = 1'b0;
  endtask

  task automatic model_apply(input logic [1:0] op, input logic [7:0] b);
    int s, sv;
    case (op)
      2'b00: begin m_cf = 1'b0; m_vf = 1'b0; end
      2'b01: begin
        s  = int'(m_acc) + int'(b) + int'(m_cf);
        sv = int'($signed(m_acc)) + int'($signed(b)) + int'(m_cf);
        m_vf = (sv > 127) || (sv < -128);
        m_acc = 8'(s); m_cf = (s > 255);
      end
      2'b10: begin
        s  = int'(m_acc) - int'(b);
        sv = int'($signed(m_acc)) - int'($signed(b));
        m_vf = (sv > 127) || (sv < -128);
        m_acc = 8'(s); m_cf = (s < 0);
      end
      default: begin m_acc = 8'h00; m_cf = 1'b0; m_vf = 1'b0; end
    endcase
    m_zf = (m_acc == 8'h00);
  endtask

  // Called on a negedge with the DUT idle; returns on the negedge where DONE is high.
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] b);
    chk("ready_idle", CMD_READY, 1);
    CMD_OP = op; CMD_B = b; CMD_VALID = 1'b1;
    @(posedge CLK); @(negedge CLK);
    CMD_VALID = 1'($urandom_range(1)); CMD_OP = 2'($urandom); CMD_B = 8'($urandom);
    chk("ready_exec", CMD_READY, 0);
    chk("done_exec", DONE, 0);
    chk("alu_op", ALU_OP, op);
    chk("alu_b", ALU_B, b);
    chk("alu_a", ALU_A, m_acc);
    chk("alu_cy", ALU_CY, m_cf);
    model_apply(op, b);
    @(posedge CLK); @(negedge CLK);
    CMD_VALID = 1'b0;
    chk("acc", ACC, m_acc);
    chk("cf", CF, m_cf);
    chk("zf", ZF, m_zf);
    chk("done", DONE, 1);
`ifdef ACC_OVF_EN
    chk("vf", VF, m_vf);
`endif
  endtask

  initial begin
    RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = 2'b00; CMD_B = 8'h00;
    model_reset();
    #3;
    chk("rst_acc", ACC, 8'h00);
    chk("rst_cf", CF, 0);
    chk("rst_zf", ZF, 1);
    chk("rst_ready", CMD_READY, 1);
    chk("rst_done", DONE, 0);
    chk("rst_aluop", ALU_OP, 2'b00);
    chk("rst_alub", ALU_B, 8'h00);
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK);

    // Carry chain
    do_cmd(OP_ADC, 8'h03); chk("cc1_acc", ACC, 8'h03); chk("cc1_cf", CF, 0);
    do_cmd(OP_ADC, 8'hFE); chk("cc2_acc", ACC, 8'h01); chk("cc2_cf", CF, 1);
    do_cmd(OP_ADC, 8'h00); chk("cc3_acc", ACC, 8'h02); chk("cc3_cf", CF, 0);
    @(negedge CLK); chk("done_single", DONE, 0);

    // Borrow then clear
    do_cmd(OP_ADC, 8'h01);
    do_cmd(OP_SUB, 8'h05);
    chk("sub_acc", ACC, 8'hFE); chk("sub_cf", CF, 1); chk("sub_zf", ZF, 0);
    do_cmd(OP_CLR, 8'h5A);
    chk("clr_acc", ACC, 8'h00); chk("clr_cf", CF, 0); chk("clr_zf", ZF, 1);

    // Back-to-back with CMD_VALID held high
    CMD_OP = OP_ADC; CMD_B = 8'h01; CMD_VALID = 1'b1;
    d_prev = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); @(negedge CLK);
      if (i == 5) CMD_VALID = 1'b0;
      chk("b2b_done", DONE, (i % 2 == 1));
      chk("b2b_ready", CMD_READY, (i % 2 == 1));
      if (i > 0 && d_prev && DONE) chk("b2b_double_done", 1, 0);
      d_prev = DONE;
    end
    for (int i = 0; i < 3; i++) model_apply(OP_ADC, 8'h01);
    chk("b2b_acc", ACC, 8'h03);
    chk("b2b_model", ACC, m_acc);
    @(negedge CLK); chk("b2b_idle_done", DONE, 0);

    // Asynchronous reset while in EXEC
    CMD_OP = OP_ADC; CMD_B = 8'h05; CMD_VALID = 1'b1;
    @(posedge CLK); @(negedge CLK);
    CMD_VALID = 1'b0;
    chk("ar_exec", CMD_READY, 0);
    #2 RST = 1'b1;
    #1;
    chk("ar_acc", ACC, 8'h00);
    chk("ar_cf", CF, 0);
    chk("ar_zf", ZF, 1);
    chk("ar_done", DONE, 0);
    chk("ar_ready", CMD_READY, 1);
    chk("ar_alub", ALU_B, 8'h00);
    model_reset();
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK);
    chk("ar_done_after", DONE, 0);
    chk("ar_ready_after", CMD_READY, 1);

`ifdef ACC_OVF_EN
    do_cmd(OP_ADC, 8'h7F);
    do_cmd(OP_ADC, 8'h01);
    chk("ovf_acc", ACC, 8'h80); chk("ovf_vf", VF, 1); chk("ovf_cf", CF, 0);
    do_cmd(OP_SUB, 8'h01);
    chk("ovf2_acc", ACC, 8'h7F); chk("ovf2_vf", VF, 1);
    do_cmd(OP_PASS, 8'h00);
    chk("ovf_pass_vf", VF, 0);
`endif

    // Randomized commands; an idle gap is inserted now and then
    for (int i = 0; i < 60; i++) begin
      do_cmd(2'($urandom), 8'($urandom));
      if ($urandom_range(3) == 0) begin
        @(negedge CLK);
        chk("rnd_gap_done", DONE, 0);
        chk("rnd_gap_acc", ACC, m_acc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_acc_ctrl.md
Name: alu_acc_ctrl

Overview:
Accumulator/sequencer stage wrapped around the 8-bit ALU (ports A, B, CY, OP, Y, ST).
- Accepts operation commands over a valid/ready handshake.
- Drives the ALU inputs from the accumulator, the carry flag and the command operand.
- Captures the ALU result (Y) and carry/borrow (ST) back into the accumulator and flags.
- Top level instantiates this block and the ALU side by side; this block does not contain the ALU.

Parameters:
- WIDTH, 8, datapath width; must equal the ALU width (8).
- ACC_INIT, 8'h00, accumulator value after reset.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  block can accept a command.
- CMD_OP  in  2  operation: 00 PASS, 01 ADC, 10 SUB, 11 CLR.
- CMD_B  in  WIDTH  operand B.
- ALU_A  out  WIDTH  to ALU A; always equals ACC.
- ALU_B  out  WIDTH  to ALU B; registered operand.
- ALU_CY  out  1  to ALU CY; always equals CF.
- ALU_OP  out  2  to ALU OP; registered opcode.
- ALU_Y  in  WIDTH  from ALU Y.
- ALU_ST  in  1  from ALU ST (bit 8 of the ALU result).
- ACC  out  WIDTH  accumulator.
- CF  out  1  carry/borrow flag.
- ZF  out  1  zero flag.
- DONE  out  1  one-cycle pulse per completed command.

Behaviour:
- One clock (CLK). Reset is asynchronous and active-high (RST).
- Reset values:
  - State IDLE.
  - ACC = ACC_INIT; CF = 0; ZF = (ACC_INIT == 0).
  - ALU_OP = 00; ALU_B = 0.
  - DONE = 0; CMD_READY = 1.
- FSM state IDLE:
  - CMD_READY = 1.
  - On an edge with CMD_VALID = 1: ALU_OP <= CMD_OP, ALU_B <= CMD_B, go to EXEC.
  - CMD_VALID = 0 keeps the block in IDLE.
- FSM state EXEC:
  - Lasts exactly 1 cycle. CMD_READY = 0; CMD_VALID is ignored.
  - ALU inputs are stable for the whole cycle; ALU_A and ALU_CY hold because ACC and CF do not change in EXEC.
  - On the next edge: ACC <= ALU_Y, CF <= ALU_ST, ZF <= (ALU_Y == 0), DONE <= 1, go to IDLE.
- Latency:
  - Accept edge k; results are visible after edge k+1.
  - DONE is high during the cycle after edge k+1.
  - Throughput: 1 command per 2 cycles.
- Back-to-back commands:
  - CMD_READY is high in the same cycle DONE pulses.
  - A command accepted in that cycle sees the already-updated ACC and CF.
- Operation semantics (result of the ALU, then captured):
  - PASS: ACC unchanged, CF <= 0 (ALU ST = 0). ZF is recomputed.
  - ADC: {CF, ACC} <= ACC + B + CF, 9-bit result. Wraps modulo 256, carry goes to CF.
  - SUB: {CF, ACC} <= ACC - B, 9-bit two's complement. Incoming CF is ignored. CF = 1 on borrow, i.e. ACC < B unsigned.
  - CLR: ACC <= 0, CF <= 0, ZF <= 1.
- RST asserted mid-operation (in EXEC):
  - Command is discarded; no DONE pulse.
  - All registers go to their reset values immediately, without waiting for CLK.
- DONE is never high for two consecutive cycles.

Optional Feature:
- Macro: ACC_OVF_EN.
- Defined: adds output port VF (1 bit, reset 0), the signed overflow flag, updated only at capture.
  - ADC: VF = (A[7] == B[7]) && (Y[7] != A[7]).
  - SUB: VF = (A[7] != B[7]) && (Y[7] != A[7]).
  - PASS, CLR: VF = 0.
- Undefined: no VF port and no overflow logic.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode constants OP_PASS = 2'b00, OP_ADC = 2'b01, OP_SUB = 2'b10, OP_CLR = 2'b11.
  - FSM state type {IDLE, EXEC}.
  - WIDTH default.
- One sub-module is natural: alu_flags.
  - Combinational; inputs A, B, Y, OP; outputs zero and, under ACC_OVF_EN, overflow.
  - alu_acc_ctrl registers its outputs at capture.

Test Plan:
- Reset: pulse RST -> ACC = 00, CF = 0, ZF = 1, CMD_READY = 1, DONE = 0, ALU_OP = 00.
- Carry chain:
  - ADC B = 03 -> ACC = 03, CF = 0.
  - ADC B = FE -> ACC = 01, CF = 1.
  - ADC B = 00 -> ACC = 02, CF = 0 (carry consumed).
- Borrow: with ACC = 03, SUB B = 05 -> ACC = FE, CF = 1, ZF = 0. Then CLR -> ACC = 00, CF = 0, ZF = 1.
- Back-to-back:
  - Hold CMD_VALID high with ADC 01, ADC 01, ADC 01 from ACC = 00 and CF = 0.
  - Commands accepted every 2nd cycle; 3 single-cycle DONE pulses; final ACC = 03.
- Async reset: assert RST between clock edges while in EXEC with ADC pending -> ACC = ACC_INIT immediately, no DONE, CMD_READY = 1 after release.
- ACC_OVF_EN: from ACC = 7F, CF = 0, ADC 01 -> ACC = 80, VF = 1, CF = 0. Then SUB 01 -> ACC = 7F, VF = 1.
